// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
//  Module   : bus_arbiter_pkg
//  Purpose  : Shared types, state encodings and master IDs for bus_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

    // Arbiter FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_BUSY   = 2'd1;
    localparam state_t ST_RESUME = 2'd2;

    // Master identifiers; the value doubles as the master mux select
    typedef logic master_t;
    localparam master_t M1 = 1'b0;
    localparam master_t M2 = 1'b1;

    // Two-master round-robin choice: with both eligible, pick the one not served last
    function automatic master_t rr_pick(input logic e1, input logic e2, input master_t last);
        if (e1 && e2) begin
            return (last == M1) ? M2 : M1;
        end else if (e2) begin
            return M2;
        end else begin
            return M1;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_split_timer.sv
// ============================================================================
//  Module   : bus_arbiter_split_timer
//  Purpose  : Saturating split-pending timer; flags the last cycle of the
//             allowed pending window and restarts from zero on expiry.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter_split_timer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic hit
);

    localparam logic [WIDTH-1:0] C_LAST = WIDTH'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q;

    // hit marks the final counting cycle; the owner sees the timeout at the next edge
    assign hit = en && !clr && (cnt_q == C_LAST);

    // Counter: clear has priority, wraps to zero only via expiry, otherwise saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || hit) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != C_MAX)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Two-master round-robin bus arbiter with single outstanding split
//             transaction tracking, resume regrant and split timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int SPLIT_TO_WIDTH = 8,
    parameter int SPLIT_TIMEOUT  = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic breq1,
    input  logic breq2,
    input  logic ssplit,
    input  logic split_rel,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic split_grant,
    output logic split_timeout,
    output logic busy
);

    state_t  state_q, state_d;
    logic    grant1_q, grant1_d;
    logic    grant2_q, grant2_d;
    master_t msel_q, msel_d;
    master_t last_q, last_d;
    logic    split_pending_q, split_pending_d;
    master_t split_owner_q, split_owner_d;
    logic    rel_latched_q, rel_latched_d;
    logic    split_grant_q, split_grant_d;
    logic    split_timeout_q, split_timeout_d;
    logic    busy_q;

    logic    elig1, elig2, any_elig, owner_req, resume_go;
    logic    timer_hit, timer_expire;
    master_t pick;

    // Arbitration inputs: the split owner is masked until resume or timeout
    assign elig1     = breq1 && !(split_pending_q && (split_owner_q == M1));
    assign elig2     = breq2 && !(split_pending_q && (split_owner_q == M2));
    assign any_elig  = elig1 || elig2;
    assign pick      = rr_pick(elig1, elig2, last_q);
    assign owner_req = (msel_q == M2) ? breq2 : breq1;
    assign resume_go = (state_q == ST_IDLE) && split_pending_q && rel_latched_q;

    // A release arriving on the expiry cycle rescues the split
    assign timer_expire = timer_hit && !split_rel;

    bus_arbiter_split_timer #(
        .WIDTH   (SPLIT_TO_WIDTH),
        .TIMEOUT (SPLIT_TIMEOUT)
    ) u_split_timer (
        .clk (clk),
        .rst (rst),
        .en  (split_pending_q && !rel_latched_q),
        .clr (!split_pending_q || rel_latched_q),
        .hit (timer_hit)
    );

    // State and registered outputs; reset leaves master 1 first in line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            grant1_q        <= 1'b0;
            grant2_q        <= 1'b0;
            msel_q          <= M1;
            last_q          <= M2;
            split_pending_q <= 1'b0;
            split_owner_q   <= M1;
            rel_latched_q   <= 1'b0;
            split_grant_q   <= 1'b0;
            split_timeout_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant1_q        <= grant1_d;
            grant2_q        <= grant2_d;
            msel_q          <= msel_d;
            last_q          <= last_d;
            split_pending_q <= split_pending_d;
            split_owner_q   <= split_owner_d;
            rel_latched_q   <= rel_latched_d;
            split_grant_q   <= split_grant_d;
            split_timeout_q <= split_timeout_d;
            busy_q          <= grant1_d || grant2_d;
        end
    end

    // Next-state: a pending resume beats fresh arbitration; a split beats a release
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (split_pending_q && rel_latched_q) begin
                    state_d = ST_RESUME;
                end else if (any_elig) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if ((ssplit && !split_pending_q) || !owner_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESUME: state_d = ST_BUSY;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / bookkeeping next values, registered one cycle ahead of the state
    always_comb begin
        grant1_d        = grant1_q;
        grant2_d        = grant2_q;
        msel_d          = msel_q;
        last_d          = last_q;
        split_pending_d = split_pending_q;
        split_owner_d   = split_owner_q;
        rel_latched_d   = rel_latched_q;
        split_grant_d   = 1'b0;
        split_timeout_d = 1'b0;

        if (timer_expire) begin
            split_pending_d = 1'b0;
            split_timeout_d = 1'b1;
        end else if (split_rel && split_pending_q) begin
            rel_latched_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (resume_go) begin
                    grant1_d        = (split_owner_q == M1);
                    grant2_d        = (split_owner_q == M2);
                    msel_d          = split_owner_q;
                    last_d          = split_owner_q;
                    split_grant_d   = 1'b1;
                    split_pending_d = 1'b0;
                    rel_latched_d   = 1'b0;
                end else if (any_elig) begin
                    grant1_d = (pick == M1);
                    grant2_d = (pick == M2);
                    msel_d   = pick;
                    last_d   = pick;
                end else begin
                    grant1_d = 1'b0;
                    grant2_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (ssplit && !split_pending_q) begin
                    split_pending_d = 1'b1;
                    split_owner_d   = msel_q;
                    grant1_d        = 1'b0;
                    grant2_d        = 1'b0;
                end else if (!owner_req) begin
                    grant1_d = 1'b0;
                    grant2_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bgrant1       = grant1_q;
    assign bgrant2       = grant2_q;
    assign msel          = msel_q;
    assign split_grant   = split_grant_q;
    assign split_timeout = split_timeout_q;
    assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
//  Module   : tb_bus_arbiter
//  Purpose  : Directed self-checking bench for bus_arbiter. Output vector is
//             {bgrant1, bgrant2, msel, split_grant, split_timeout, busy}.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic breq1 = 1'b0, breq2 = 1'b0, ssplit = 1'b0, split_rel = 1'b0;
    logic bgrant1, bgrant2, msel, split_grant, split_timeout, busy;

    typedef struct {
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    bus_arbiter #(
        .SPLIT_TO_WIDTH (8),
        .SPLIT_TIMEOUT  (200)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .breq1         (breq1),
        .breq2         (breq2),
        .ssplit        (ssplit),
        .split_rel     (split_rel),
        .bgrant1       (bgrant1),
        .bgrant2       (bgrant2),
        .msel          (msel),
        .split_grant   (split_grant),
        .split_timeout (split_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it against the live outputs
    task automatic check_head();
        exp_t       e;
        logic [5:0] obs;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: observed none expected entry");
            return;
        end
        e   = sb_q.pop_front();
        obs = {bgrant1, bgrant2, msel, split_grant, split_timeout, busy};
        n_tests++;
        assert (obs === e.v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then check
    task automatic step(input logic b1, input logic b2, input logic ss, input logic sr,
                        input logic [5:0] ev, input string tag);
        exp_t e;
        breq1     = b1;
        breq2     = b2;
        ssplit    = ss;
        split_rel = sr;
        e.v   = ev;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_head();
    endtask

    // Check outputs at the current time without a clock edge
    task automatic check_now(input logic [5:0] ev, input string tag);
        exp_t e;
        e.v   = ev;
        e.tag = tag;
        sb_q.push_back(e);
        check_head();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_now(6'b000000, "reset_state");
        rst = 1'b0;

        // 1: simultaneous requests, master 1 first, then master 2 after an idle cycle
        step(1, 1, 0, 0, 6'b100001, "t1_both_m1_first");
        step(0, 1, 0, 0, 6'b000000, "t1_m1_release");
        step(0, 1, 0, 0, 6'b011001, "t1_m2_grant");
        step(0, 0, 0, 0, 6'b001000, "t1_m2_release");
        step(0, 0, 0, 0, 6'b001000, "t1_idle");

        // 2: master 1 alone three times, then round-robin hands over to master 2
        step(1, 0, 0, 0, 6'b100001, "t2_m1_a");
        step(1, 0, 0, 0, 6'b100001, "t2_m1_a_hold");
        step(0, 0, 0, 0, 6'b000000, "t2_m1_a_rel");
        step(1, 0, 0, 0, 6'b100001, "t2_m1_b");
        step(0, 0, 0, 0, 6'b000000, "t2_m1_b_rel");
        step(1, 0, 0, 0, 6'b100001, "t2_m1_c");
        step(1, 1, 0, 0, 6'b100001, "t2_m1_c_hold_m2_waits");
        step(0, 1, 0, 0, 6'b000000, "t2_m1_c_rel");
        step(1, 1, 0, 0, 6'b011001, "t2_rr_m2");
        step(0, 0, 0, 0, 6'b001000, "t2_m2_rel");

        // 3: split on master 1, master 2 takes the bus, master 1 masked
        step(1, 0, 0, 0, 6'b100001, "t3_m1_grant");
        step(1, 1, 1, 0, 6'b000000, "t3_split_drop");
        step(1, 1, 0, 0, 6'b011001, "t3_m2_grant_m1_masked");
        step(1, 1, 1, 0, 6'b011001, "t3_second_split_ignored");

        // 4: release during master 2 transfer waits, then resume master 1
        step(1, 1, 0, 1, 6'b011001, "t4_rel_no_preempt");
        step(1, 1, 0, 0, 6'b011001, "t4_m2_hold");
        step(1, 0, 0, 0, 6'b001000, "t4_m2_release");
        step(1, 0, 0, 0, 6'b100101, "t4_resume_split_grant");
        step(1, 0, 0, 0, 6'b100001, "t4_split_grant_one_cycle");
        step(0, 0, 0, 0, 6'b000000, "t4_m1_release");

        // 5: split never released, timeout after SPLIT_TIMEOUT cycles
        step(1, 0, 0, 0, 6'b100001, "t5_m1_grant");
        step(1, 0, 1, 0, 6'b000000, "t5_split");
        for (int i = 0; i < 199; i++) begin
            step(1, 0, 0, 0, 6'b000000, "t5_pending_masked");
        end
        step(1, 0, 0, 0, 6'b000010, "t5_timeout_pulse");
        step(1, 0, 0, 0, 6'b100001, "t5_m1_rearbitrates");
        step(0, 0, 0, 0, 6'b000000, "t5_m1_release");

        // 6: asynchronous reset mid-transfer with a split pending
        step(1, 0, 0, 0, 6'b100001, "t6_m1_grant");
        step(1, 1, 1, 0, 6'b000000, "t6_split");
        step(1, 1, 0, 0, 6'b011001, "t6_m2_grant");
        rst = 1'b1;
        #1;
        check_now(6'b000000, "t6_async_reset");
        #1;
        rst = 1'b0;
        step(0, 0, 0, 1, 6'b000000, "t6_rel_ignored");
        step(1, 1, 0, 0, 6'b100001, "t6_m1_first_after_reset");

        // Split and owner release in the same cycle: the split is recorded
        step(0, 1, 1, 0, 6'b000000, "b_split_beats_release");
        step(1, 0, 0, 0, 6'b000000, "b_owner_masked");
        step(1, 0, 0, 1, 6'b000000, "b_rel_latched");
        step(1, 0, 0, 0, 6'b100101, "b_resume");
        step(1, 0, 0, 0, 6'b100001, "b_resume_hold");
        step(0, 0, 0, 0, 6'b000000, "b_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
